dot_product_sequencer: RTL
==========================

DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, meaning signed width of each addend.
REQ-002 SHALL have parameter LENGTH, default 9, meaning addends per beat (adder tree width).
REQ-003 SHALL have parameter BEATS, default 4, meaning maximum beats per vector (BEATS >= 1).
REQ-004 SHALL derive TREE_WIDTH = DATA_WIDTH + $clog2(LENGTH), ACC_WIDTH = TREE_WIDTH + $clog2(BEATS), CNT_WIDTH = $clog2(BEATS+1).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  beat offered.
REQ-008 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_addends  input  LENGTH x DATA_WIDTH signed  one beat of addends.
REQ-010 SHALL have port in_last  input  1  beat is final beat of current vector.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-013 SHALL have port out_sum  output  ACC_WIDTH signed  vector sum.
REQ-014 SHALL have port out_beats  output  CNT_WIDTH  number of beats summed into out_sum (1..BEATS).

Function
REQ-015 SHALL reduce each accepted beat with one combinational AdderTree (LENGTH addends, DATA_WIDTH) to a TREE_WIDTH signed partial sum, sign-extended to ACC_WIDTH.
REQ-016 SHALL implement states ACCUM (accepting beats, no result pending) and OUTPUT (result held, out_valid=1).
REQ-017 SHALL drive in_ready = 1 in ACCUM, and in OUTPUT in_ready = out_ready (combinational pass-through).
REQ-018 SHALL, on the first accepted beat of a vector, load acc = partial sum and beat count = 1 (no separate clear cycle).
REQ-019 SHALL, on each subsequent accepted beat, set acc = acc + partial sum and count = count + 1.
REQ-020 SHALL terminate a vector on the accepted beat with in_last=1 or on the accepted beat making count = BEATS, whichever is first; in_last on beat BEATS is redundant, not an error.
REQ-021 SHALL, at the clock edge after the terminating beat, enter OUTPUT with out_sum = final acc, out_beats = final count, out_valid = 1 (latency 1 cycle).
REQ-022 SHALL hold out_sum, out_beats, out_valid stable in OUTPUT while out_ready = 0.
REQ-023 SHALL, in OUTPUT with out_ready = 1 and no input beat accepted, return to ACCUM with out_valid = 0 next cycle.
REQ-024 SHALL, in OUTPUT with out_ready = 1 and a beat accepted in the same cycle, treat that beat as first beat of a new vector (REQ-018); if it also terminates (in_last or BEATS = 1), stay in OUTPUT with the new result next cycle (full throughput, no bubble).
REQ-025 SHALL never wrap acc: ACC_WIDTH holds LENGTH*BEATS*(-2^(DATA_WIDTH-1)) exactly; no saturation logic.
REQ-026 SHALL ignore in_addends and in_last when no handshake occurs.

Reset
REQ-027 SHALL, while reset_n = 0 at a rising clk edge, set state = ACCUM, acc = 0, count = 0, out_sum = 0, out_beats = 0, out_valid = 0.
REQ-028 SHALL discard any partially accumulated vector or pending result on reset; first beat after reset starts a new vector.
REQ-029 SHALL drive in_ready = 1 during and immediately after reset (state ACCUM); beats presented while reset_n = 0 are not accumulated.

Structure
REQ-030 SHALL place the width-derivation functions (TREE_WIDTH, ACC_WIDTH, CNT_WIDTH) and the state enum typedef in a shared package, adder_tree_pkg.
REQ-031 SHALL instantiate the existing AdderTree module as its sole sub-module; all sequencing lives in dot_product_sequencer.

Verification (DATA_WIDTH=5, LENGTH=9, BEATS=4; beat P = {1,-2,3,-4,5,-6,7,-8,9}, tree sum 5)
REQ-032 SHALL check: four P beats back-to-back, in_last on 4th, out_ready=1 -> one cycle later out_valid=1, out_sum=20, out_beats=4.
REQ-033 SHALL check: two P beats, in_last on 2nd -> out_sum=10, out_beats=2; four beats with in_last never asserted -> forced termination, out_sum=20, out_beats=4.
REQ-034 SHALL check: result pending, out_ready=0 for 3 cycles -> out_sum/out_beats stable, in_ready=0; out_ready=1 -> accepted, out_valid=0 next cycle.
REQ-035 SHALL check: two vectors streamed with in_valid=1 and out_ready=1 continuously -> second vector's first beat accepted in the cycle the first result is taken, no idle cycle.
REQ-036 SHALL check: reset_n=0 for one cycle after two beats, then four beats of all -16 -> out_sum=-576, out_beats=4 (no residue from aborted vector).

Source files
------------

// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared width helpers and sequencer state type
//
// Purpose: width derivations shared by adder_tree and dot_product_sequencer,
// plus the sequencer state enumeration.
// Contents:
//   tree_width(dw, len)       signed width of one reduced beat
//   acc_width(dw, len, beats) signed width of a whole-vector sum
//   cnt_width(beats)          width able to hold 0..beats
//   seq_state_e               ACCUM / OUTPUT

package adder_tree_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } seq_state_e;

  function automatic int tree_width(input int data_width, input int length);
    return data_width + $clog2(length);
  endfunction

  function automatic int acc_width(input int data_width, input int length, input int beats);
    return tree_width(data_width, length) + $clog2(beats);
  endfunction

  function automatic int cnt_width(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/adder_tree.sv
// rtl/adder_tree.sv - combinational signed reduction of one beat of addends
//
// Purpose: sums LENGTH signed DATA_WIDTH addends into one TREE_WIDTH result.
// Ports:
//   addends  in   LENGTH x DATA_WIDTH packed, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sum      out  TREE_WIDTH signed sum of all addends

module adder_tree
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int LENGTH     = 9,
  localparam int TREE_WIDTH = tree_width(DATA_WIDTH, LENGTH)
) (
  input  logic [LENGTH*DATA_WIDTH-1:0] addends,
  output logic signed [TREE_WIDTH-1:0] sum
);

  logic signed [DATA_WIDTH-1:0] elem [LENGTH];
  logic signed [TREE_WIDTH-1:0] total;

  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      elem[i] = addends[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // TREE_WIDTH carries $clog2(LENGTH) guard bits, so the running total
  // cannot overflow even with every addend at the most negative value.
  always_comb begin
    total = '0;
    for (int i = 0; i < LENGTH; i++) begin
      total = total + TREE_WIDTH'(elem[i]);
    end
  end

  assign sum = total;

endmodule

// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - accumulates multi-beat vectors into one sum
//
// Purpose: reduces each accepted beat with adder_tree and accumulates beats
// until in_last or BEATS beats, then presents the vector sum on a
// valid/ready output while the next vector may already start.
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   in_valid/in_ready          input beat handshake
//   in_addends, in_last        beat payload, final-beat marker
//   out_valid/out_ready        result handshake
//   out_sum, out_beats         vector sum, number of beats summed

module dot_product_sequencer
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int LENGTH     = 9,
  parameter int BEATS      = 4,
  localparam int TREE_WIDTH = tree_width(DATA_WIDTH, LENGTH),
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, LENGTH, BEATS),
  localparam int CNT_WIDTH  = cnt_width(BEATS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LENGTH*DATA_WIDTH-1:0] in_addends,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  out_sum,
  output logic [CNT_WIDTH-1:0]         out_beats
);

  seq_state_e state, state_next;

  logic signed [TREE_WIDTH-1:0] partial;
  logic signed [ACC_WIDTH-1:0]  partial_ext;
  logic signed [ACC_WIDTH-1:0]  acc, acc_next;
  logic [CNT_WIDTH-1:0]         count, count_next;
  logic                         fire;
  logic                         terminate;

  adder_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .LENGTH     (LENGTH)
  ) u_adder_tree (
    .addends (in_addends),
    .sum     (partial)
  );

  assign partial_ext = ACC_WIDTH'(partial);

  // A pending result may be replaced in the same cycle it is taken.
  assign in_ready  = (state == ACCUM) || out_ready;
  assign out_valid = (state == OUTPUT);
  assign fire      = in_valid && in_ready;

  // count is cleared whenever a vector terminates, so count == 0 marks the
  // first beat of a vector both in ACCUM and in OUTPUT.
  assign acc_next   = (count == '0) ? partial_ext : acc + partial_ext;
  assign count_next = count + 1'b1;
  assign terminate  = fire && (in_last || (count_next == CNT_WIDTH'(BEATS)));

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: begin
        if (terminate) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready && !terminate) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      out_sum   <= '0;
      out_beats <= '0;
    end else begin
      state <= state_next;
      if (fire) begin
        if (terminate) begin
          out_sum   <= acc_next;
          out_beats <= count_next;
          acc       <= '0;
          count     <= '0;
        end else begin
          acc   <= acc_next;
          count <= count_next;
        end
      end
    end
  end

endmodule
